tt_um_zhwa_rgb_mixer: RTL and testbench

- Tiny Tapeout user project: three quadrature rotary encoders each set an 8-bit level.
- Each level drives one PWM output channel (R/G/B LED brightness).
- Encoder inputs are synchronised and debounced, decoded into up/down steps, accumulated in 8-bit registers, and compared against a shared free-running PWM counter.

---
 rtl/rgb_mixer_pkg.sv | 13 +
 rtl/tt_um_zhwa_rgb_mixer_debounce.sv | 47 ++++
 rtl/tt_um_zhwa_rgb_mixer_encoder.sv | 38 +++
 rtl/tt_um_zhwa_rgb_mixer_pwm.sv | 28 ++
 rtl/tt_um_zhwa_rgb_mixer.sv | 71 +++++++
 tb/tb_tt_um_zhwa_rgb_mixer.sv | 236 +++++++++++++++++++++++
 6 files changed

// File: rtl/rgb_mixer_pkg.sv
// Shared constants and types for the RGB mixer.
//   WIDTH        : level register and PWM counter width
//   DEBOUNCE_LEN : consecutive identical synchronised samples before a debounced input moves
//   NUM_CHANNELS : number of encoder/PWM channels
package rgb_mixer_pkg;

  localparam int unsigned WIDTH        = 8;
  localparam int unsigned DEBOUNCE_LEN = 8;
  localparam int unsigned NUM_CHANNELS = 3;

  typedef logic [WIDTH-1:0] level_t;

endpackage

// File: rtl/tt_um_zhwa_rgb_mixer_debounce.sv
// Two-flop synchroniser followed by a sample-history debouncer for one encoder pin.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   in_i          : raw asynchronous pin
//   out_o         : debounced level; moves only after Len identical synchronised samples
module tt_um_zhwa_rgb_mixer_debounce
  import rgb_mixer_pkg::*;
#(
  parameter int unsigned Len = DEBOUNCE_LEN
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic in_i,
  output logic out_o
);

  logic [1:0]     sync_q;
  logic [Len-2:0] hist_q;
  logic [Len-1:0] window;
  logic           out_q, out_d;

  // The window includes the sample entering this cycle, so only Len-1 older samples are stored.
  assign window = {hist_q, sync_q[1]};

  always_comb begin
    out_d = out_q;
    if (&window) begin
      out_d = 1'b1;
    end else if (~|window) begin
      out_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      hist_q <= '0;
      out_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], in_i};
      hist_q <= window[Len-2:0];
      out_q  <= out_d;
    end
  end

  assign out_o = out_q;

endmodule

// File: rtl/tt_um_zhwa_rgb_mixer_encoder.sv
// Quadrature decoder and level accumulator for one channel.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   a_i, b_i      : debounced encoder phases
//   level_o       : 8-bit level, wraps modulo 2^WIDTH
module tt_um_zhwa_rgb_mixer_encoder
  import rgb_mixer_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   a_i,
  input  logic   b_i,
  output level_t level_o
);

  logic   a_prev_q;
  level_t level_q, level_d;

  // Only A edges count; B just selects direction, evaluated on its current value.
  always_comb begin
    level_d = level_q;
    if (a_i != a_prev_q) begin
      level_d = (a_i != b_i) ? level_q + WIDTH'(1) : level_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_prev_q <= 1'b0;
      level_q  <= '0;
    end else begin
      a_prev_q <= a_i;
      level_q  <= level_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/tt_um_zhwa_rgb_mixer_pwm.sv
// Registered PWM comparator against the shared counter.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   counter_i     : shared free-running counter
//   level_i       : channel level
//   pwm_o         : high while counter < level
module tt_um_zhwa_rgb_mixer_pwm
  import rgb_mixer_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_ni,
  input  level_t counter_i,
  input  level_t level_i,
  output logic   pwm_o
);

  logic pwm_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pwm_q <= 1'b0;
    end else begin
      pwm_q <= (counter_i < level_i);
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/tt_um_zhwa_rgb_mixer.sv
// Tiny Tapeout RGB mixer: three rotary encoders each set an 8-bit level driving one PWM output.
//   clk, rst_n : clock, asynchronous active-low reset
//   ena        : design selected (ignored)
//   ui_in      : [2c]=enc c phase A, [2c+1]=enc c phase B, [7:6] unused
//   uo_out     : [c]=pwm c, [7:3] zero
//   uio_in     : unused; uio_out, uio_oe tied 0
module tt_um_zhwa_rgb_mixer
  import rgb_mixer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int unsigned NumInputs = 2 * NUM_CHANNELS;

  logic [NumInputs-1:0]    enc_deb;
  level_t                  level [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] pwm;
  level_t                  counter_q;
  logic                    unused;

  assign unused = ^{ena, ui_in[7:NumInputs], uio_in};

  for (genvar i = 0; i < NumInputs; i++) begin : g_deb
    tt_um_zhwa_rgb_mixer_debounce #(
      .Len (DEBOUNCE_LEN)
    ) u_debounce (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .in_i   (ui_in[i]),
      .out_o  (enc_deb[i])
    );
  end

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
    tt_um_zhwa_rgb_mixer_encoder u_encoder (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .a_i     (enc_deb[2*c]),
      .b_i     (enc_deb[2*c+1]),
      .level_o (level[c])
    );

    tt_um_zhwa_rgb_mixer_pwm u_pwm (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .counter_i (counter_q),
      .level_i   (level[c]),
      .pwm_o     (pwm[c])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter_q <= '0;
    end else begin
      counter_q <= counter_q + WIDTH'(1);
    end
  end

  assign uo_out  = {{(8 - NUM_CHANNELS){1'b0}}, pwm};
  assign uio_out = '0;
  assign uio_oe  = '0;

endmodule

// File: tb/tb_tt_um_zhwa_rgb_mixer.sv
module tb_tt_um_zhwa_rgb_mixer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = '0;
  logic [7:0] uio_in = '0;
  wire  [7:0] uo_out, uio_out, uio_oe;

  int errors = 0;
  int checks = 0;

  tt_um_zhwa_rgb_mixer dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // pins[k] = encoder pins seen at the k-th most recent rising edge.
  // The debounced value after edge n looks at the synchronised samples pins[n-2 .. n-9].
  bit [5:0] pins [10];
  bit [5:0] deb_cur, deb_prev;  // debounced values after the last and the one-before edges
  int       m_lvl [3];
  bit [2:0] m_pwm;
  int       n;

  task automatic model_reset();
    for (int k = 0; k < 10; k++) pins[k] = '0;
    deb_cur = '0;
    deb_prev = '0;
    for (int c = 0; c < 3; c++) m_lvl[c] = 0;
    m_pwm = '0;
    n = 0;
  endtask

  task automatic model_step();
    bit [5:0] nd;
    n++;
    for (int k = 9; k > 0; k--) pins[k] = pins[k-1];
    pins[0] = ui_in[5:0];
    // PWM output after this edge compares the counter and level held before it.
    for (int c = 0; c < 3; c++) m_pwm[c] = (((n - 1) % 256) < m_lvl[c]);
    for (int c = 0; c < 3; c++) begin
      if (deb_cur[2*c] != deb_prev[2*c]) begin
        if (deb_cur[2*c] != deb_cur[2*c+1]) m_lvl[c] = (m_lvl[c] + 1) % 256;
        else                                m_lvl[c] = (m_lvl[c] + 255) % 256;
      end
    end
    for (int i = 0; i < 6; i++) begin
      int ones = 0;
      for (int k = 2; k < 10; k++) ones += pins[k][i];
      if (ones == 8)      nd[i] = 1'b1;
      else if (ones == 0) nd[i] = 1'b0;
      else                nd[i] = deb_cur[i];
    end
    deb_prev = deb_cur;
    deb_cur = nd;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      checks++;
      if (uo_out !== {5'b0, m_pwm} || uio_out !== 8'h00 || uio_oe !== 8'h00) begin
        errors++;
        $display("FAIL cycle_cmp t=%0t uo_out=%h expected=%h uio_out=%h uio_oe=%h",
                 $time, uo_out, {5'b0, m_pwm}, uio_out, uio_oe);
      end
    end
  end

  // ---------------- helpers ----------------
  bit [1:0] es [3];  // {a,b} per encoder
  bit [1:0] up_seq [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
  bit [1:0] dn_seq [4] = '{2'b01, 2'b11, 2'b10, 2'b00};

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Drive current encoder state and hold for cyc clocks; returns at posedge+2.
  task automatic apply(input int cyc);
    for (int c = 0; c < 3; c++) begin
      ui_in[2*c]   = es[c][1];
      ui_in[2*c+1] = es[c][0];
    end
    repeat (cyc) @(posedge clk);
    #2;
  endtask

  task automatic detent(input int c, input bit up, input int hold);
    for (int p = 0; p < 4; p++) begin
      es[c] = up ? up_seq[p] : dn_seq[p];
      apply(hold);
    end
  endtask

  task automatic duty(input int c, input int exp, input string name);
    int cnt = 0;
    repeat (256) begin
      @(negedge clk);
      cnt += int'(uo_out[c]);
    end
    check_int(name, cnt, exp);
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input int cyc);
    rst_n = 1'b0;
    ui_in = '0;
    for (int c = 0; c < 3; c++) es[c] = 2'b00;
    repeat (cyc) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int c = 0; c < 3; c++) es[c] = 2'b00;
    rst_n = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    check_int("reset_uo_out", int'(uo_out), 0);
    check_int("reset_uio_out", int'(uio_out), 0);
    check_int("reset_uio_oe", int'(uio_oe), 0);
    rst_n = 1'b1;
    repeat (256) @(posedge clk);
    #2;
    duty(0, 0, "idle_pwm0");
    duty(1, 0, "idle_pwm1");
    duty(2, 0, "idle_pwm2");

    // Increment: 10 up detents on enc0 -> 20
    for (int d = 0; d < 10; d++) detent(0, 1'b1, 20);
    apply(20);
    check_int("inc_model_lvl0", m_lvl[0], 20);
    duty(0, 20, "inc_duty_pwm0");
    duty(1, 0, "inc_duty_pwm1");
    duty(2, 0, "inc_duty_pwm2");

    // Decrement and wrap on enc1: B rise alone, then A rise with B=1 -> 255
    do_reset(3);
    es[1] = 2'b01;
    apply(20);
    es[1] = 2'b11;
    apply(20);
    check_int("wrap_down_model_lvl1", m_lvl[1], 255);
    duty(1, 255, "wrap_down_duty_pwm1");

    // Independence: enc2 +4 while enc0 -2
    do_reset(3);
    for (int p = 0; p < 8; p++) begin
      es[2] = up_seq[p % 4];
      if (p < 4) es[0] = dn_seq[p];
      apply(20);
    end
    apply(20);
    check_int("indep_model_lvl2", m_lvl[2], 4);
    check_int("indep_model_lvl0", m_lvl[0], 254);
    duty(2, 4, "indep_duty_pwm2");
    duty(0, 254, "indep_duty_pwm0");
    duty(1, 0, "indep_duty_pwm1");

    // Debounce: 5-clock glitch on enc0 A is ignored, then a stable rise counts once
    es[0] = 2'b10;
    apply(5);
    es[0] = 2'b00;
    apply(30);
    check_int("glitch_model_lvl0", m_lvl[0], 254);
    es[0] = 2'b10;
    apply(20);
    check_int("stable_model_lvl0", m_lvl[0], 255);
    duty(0, 255, "stable_duty_pwm0");
    // 255 + 1 -> 0: B rise (no count), then A fall with B=1
    es[0] = 2'b11;
    apply(20);
    es[0] = 2'b01;
    apply(20);
    check_int("wrap_up_model_lvl0", m_lvl[0], 0);
    duty(0, 0, "wrap_up_duty_pwm0");
    // Simultaneous A and B change, judged on the new values (a=1,b=0 -> up)
    es[0] = 2'b10;
    apply(20);
    check_int("simul_model_lvl0", m_lvl[0], 1);
    duty(0, 1, "simul_duty_pwm0");

    // Randomised pin activity, including bounces shorter than the debounce window
    for (int r = 0; r < 200; r++) begin
      ui_in = 8'($urandom);
      repeat ($urandom_range(1, 25)) @(posedge clk);
      #2;
    end

    // Mid-operation reset from level 100
    do_reset(3);
    for (int d = 0; d < 50; d++) detent(0, 1'b1, 12);
    apply(20);
    check_int("pre_reset_model_lvl0", m_lvl[0], 100);
    duty(0, 100, "pre_reset_duty_pwm0");
    rst_n = 1'b0;
    #1;
    check_int("async_reset_uo_out", int'(uo_out), 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    duty(0, 0, "post_reset_duty_pwm0");
    check_int("post_reset_model_lvl0", m_lvl[0], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
